// File: rtl/mem_stage_sram_pkg.sv
// Shared constants for the MEM stage: address width, SRAM geometry and
// controller state encodings.
package mem_stage_sram_pkg;

   localparam int ADDRESS_LEN   = 32;
   localparam int MEM_BASE_DFLT = 1024;
   localparam int SRAM_DW_DFLT  = 16;
   localparam int SRAM_AW_DFLT  = 18;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RD_LO = 3'd1;
   localparam logic [2:0] S_RD_HI = 3'd2;
   localparam logic [2:0] S_WR_LO = 3'd3;
   localparam logic [2:0] S_WR_HI = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

endpackage

// File: rtl/sram_ctrl.sv
// Sequences one 32-bit load/store as two halfword accesses on an async
// SRAM and holds the pipeline off (ready=0) until the word is done.
module sram_ctrl
   import mem_stage_sram_pkg::*;
#(
   parameter int DATA_W      = ADDRESS_LEN,
   parameter int SRAM_DW     = SRAM_DW_DFLT,
   parameter int SRAM_AW     = SRAM_AW_DFLT,
   parameter int WAIT_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_req,
   input  logic               wr_req,
   input  logic [SRAM_AW-2:0] word_addr,
   input  logic [DATA_W-1:0]  wdata,
   output logic [DATA_W-1:0]  rdata,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [SRAM_DW-1:0] sram_dq_out,
   input  logic [SRAM_DW-1:0] sram_dq_in,
   output logic               sram_dq_oe,
   output logic               sram_we_n,
   output logic               sram_oe_n
);

   // Read phases last WAIT_CYCLES+1 cycles; write phases add a recovery cycle.
   localparam logic [1:0] RD_LAST = 2'(WAIT_CYCLES);
   localparam logic [1:0] WR_LAST = 2'(WAIT_CYCLES + 1);

   logic [2:0]         state;
   logic [1:0]         cnt;
   logic               rd_op;
   logic [SRAM_DW-1:0] lo, hi;
   logic [DATA_W-1:0]  mem_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         rd_op <= 1'b0;
         lo    <= '0;
         hi    <= '0;
         mem_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               cnt   <= '0;
               rd_op <= rd_req;
               if (rd_req)      state <= S_RD_LO;
               else if (wr_req) state <= S_WR_LO;
            end
            S_RD_LO: begin
               if (cnt == RD_LAST) begin
                  lo    <= sram_dq_in;
                  cnt   <= '0;
                  state <= S_RD_HI;
               end else cnt <= cnt + 2'd1;
            end
            S_RD_HI: begin
               if (cnt == RD_LAST) begin
                  hi    <= sram_dq_in;
                  cnt   <= '0;
                  state <= S_DONE;
               end else cnt <= cnt + 2'd1;
            end
            S_WR_LO: begin
               if (cnt == WR_LAST) begin
                  cnt   <= '0;
                  state <= S_WR_HI;
               end else cnt <= cnt + 2'd1;
            end
            S_WR_HI: begin
               if (cnt == WR_LAST) begin
                  cnt   <= '0;
                  state <= S_DONE;
               end else cnt <= cnt + 2'd1;
            end
            S_DONE: begin
               if (rd_op) mem_q <= {hi, lo};
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // MEM/WB samples at the DONE edge, so the fresh word is bypassed during DONE.
   assign rdata = (state == S_DONE && rd_op) ? {hi, lo} : mem_q;

   assign ready = (state == S_IDLE && !rd_req && !wr_req) || (state == S_DONE);

   always_comb begin
      sram_addr   = '0;
      sram_dq_out = '0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;
      sram_oe_n   = 1'b1;
      case (state)
         S_RD_LO: begin
            sram_addr = {word_addr, 1'b0};
            sram_oe_n = 1'b0;
         end
         S_RD_HI: begin
            sram_addr = {word_addr, 1'b1};
            sram_oe_n = 1'b0;
         end
         S_WR_LO: begin
            sram_addr   = {word_addr, 1'b0};
            sram_dq_out = wdata[SRAM_DW-1:0];
            sram_dq_oe  = 1'b1;
            sram_we_n   = (cnt == WR_LAST);
         end
         S_WR_HI: begin
            sram_addr   = {word_addr, 1'b1};
            sram_dq_out = wdata[DATA_W-1:SRAM_DW];
            sram_dq_oe  = 1'b1;
            sram_we_n   = (cnt == WR_LAST);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage_sram.sv
// MEM pipeline stage: forwards writeback control, maps the byte address onto
// SRAM word slots and runs loads/stores through sram_ctrl.
module mem_stage_sram
   import mem_stage_sram_pkg::*;
#(
   parameter int DATA_W      = ADDRESS_LEN,
   parameter int SRAM_DW     = SRAM_DW_DFLT,
   parameter int SRAM_AW     = SRAM_AW_DFLT,
   parameter int MEM_BASE    = MEM_BASE_DFLT,
   parameter int WAIT_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               WB_EN,
   input  logic               MEM_R_EN,
   input  logic               MEM_W_EN,
   input  logic [DATA_W-1:0]  ALU_Res,
   input  logic [DATA_W-1:0]  Val_Rm,
   input  logic [3:0]         Dest,
   output logic               WB_EN_out,
   output logic               MEM_R_EN_out,
   output logic [DATA_W-1:0]  ALU_Res_out,
   output logic [DATA_W-1:0]  Mem_Data,
   output logic [3:0]         Dest_out,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [SRAM_DW-1:0] sram_dq_out,
   input  logic [SRAM_DW-1:0] sram_dq_in,
   output logic               sram_dq_oe,
   output logic               sram_we_n,
   output logic               sram_oe_n
);

   localparam logic [DATA_W-1:0] BASE = DATA_W'(MEM_BASE);

   logic               borrow;
   logic [SRAM_AW-2:0] word_addr;

   assign WB_EN_out    = WB_EN;
   assign MEM_R_EN_out = MEM_R_EN;
   assign ALU_Res_out  = ALU_Res;
   assign Dest_out     = Dest;

   // Only off[SRAM_AW:2] matters; the borrow out of bits [1:0] keeps it exact
   // without building the full-width subtraction.
   assign borrow    = ALU_Res[1:0] < BASE[1:0];
   assign word_addr = ALU_Res[SRAM_AW:2] - BASE[SRAM_AW:2]
                      - {{(SRAM_AW-2){1'b0}}, borrow};

   sram_ctrl #(
      .DATA_W      (DATA_W),
      .SRAM_DW     (SRAM_DW),
      .SRAM_AW     (SRAM_AW),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .rd_req      (MEM_R_EN),
      .wr_req      (MEM_W_EN),
      .word_addr   (word_addr),
      .wdata       (Val_Rm),
      .rdata       (Mem_Data),
      .ready       (ready),
      .sram_addr   (sram_addr),
      .sram_dq_out (sram_dq_out),
      .sram_dq_in  (sram_dq_in),
      .sram_dq_oe  (sram_dq_oe),
      .sram_we_n   (sram_we_n),
      .sram_oe_n   (sram_oe_n)
   );

endmodule

// File: tb/tb_mem_stage_sram.sv
// Scoreboard bench for mem_stage_sram: a stimulus process queues expected
// responses, a monitor pops them whenever the stage completes an op (ready=1).
module tb_mem_stage_sram;

   logic        clk, rst;
   logic        WB_EN, MEM_R_EN, MEM_W_EN;
   logic [31:0] ALU_Res, Val_Rm;
   logic [3:0]  Dest;
   logic        WB_EN_out, MEM_R_EN_out;
   logic [31:0] ALU_Res_out, Mem_Data;
   logic [3:0]  Dest_out;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
   logic        sram_dq_oe, sram_we_n, sram_oe_n;

   mem_stage_sram dut (
      .clk(clk), .rst(rst), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
      .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .Dest(Dest),
      .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out), .ALU_Res_out(ALU_Res_out),
      .Mem_Data(Mem_Data), .Dest_out(Dest_out), .ready(ready),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
      .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Asynchronous SRAM model.
   logic [15:0] mem [0:(1<<18)-1];
   assign sram_dq_in = sram_oe_n ? 16'h0000 : mem[sram_addr];
   always @(negedge clk) if (!sram_we_n && sram_dq_oe) mem[sram_addr] = sram_dq_out;

   typedef struct {
      logic [31:0] mem_data;
      logic [31:0] alu;
      logic        wb, mr;
      logic [3:0]  dest;
      int          stall, we_cyc, oe_cyc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0, n_err = 0;
   int   stall_c = 0, we_c = 0, oe_c = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: measures the stall and SRAM strobe activity, checks on completion.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         stall_c = 0; we_c = 0; oe_c = 0;
      end else if (!ready) begin
         stall_c++;
         if (!sram_we_n) we_c++;
         if (sram_dq_oe) oe_c++;
      end else begin
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("stall_cycles", stall_c, e.stall);
            chk("we_low_cycles", we_c, e.we_cyc);
            chk("dq_oe_cycles", oe_c, e.oe_cyc);
            chk("mem_data", Mem_Data, e.mem_data);
            chk("alu_res_out", ALU_Res_out, e.alu);
            chk("ctl_out", {26'd0, WB_EN_out, MEM_R_EN_out, Dest_out}, {26'd0, e.wb, e.mr, e.dest});
            chk("pins_idle", {11'd0, sram_addr, sram_dq_oe, sram_we_n, sram_oe_n}, {11'd0, 18'd0, 3'b011});
         end
         stall_c = 0; we_c = 0; oe_c = 0;
      end
   end

   task automatic idle_in();
      WB_EN = 0; MEM_R_EN = 0; MEM_W_EN = 0; ALU_Res = 0; Val_Rm = 0; Dest = 0;
   endtask

   task automatic do_op(input logic r, input logic w, input logic wb, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] ds, input logic [31:0] exp_md,
                        input int stall, input int we_cyc, input int oe_cyc);
      exp_t e;
      bit   done = 0;
      MEM_R_EN = r; MEM_W_EN = w; WB_EN = wb; ALU_Res = a; Val_Rm = d; Dest = ds;
      e.mem_data = exp_md; e.alu = a; e.wb = wb; e.mr = r; e.dest = ds;
      e.stall = stall; e.we_cyc = we_cyc; e.oe_cyc = oe_cyc;
      sb.push_back(e);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ready) begin done = 1; break; end
      end
      if (!done) begin
         n_cmp++; n_err++;
         $display("FAIL op_timeout: ready never rose for addr %h", a);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      mem[0] = 16'hA5A5; mem[1] = 16'h5A5A; mem[4] = 16'h0000; mem[5] = 16'h0000;
      idle_in();
      rst = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_mem_data", Mem_Data, 32'h0);
      chk("rst_pins", {11'd0, sram_addr, sram_dq_oe, sram_we_n, sram_oe_n}, {11'd0, 18'd0, 3'b011});
      @(posedge clk); #1 rst = 0;

      // store 1032 -> halfwords 4/5
      do_op(0, 1, 0, 32'd1032, 32'hDEADBEEF, 4'd0, 32'h0, 7, 4, 6);
      chk("sram_hw4", {16'd0, mem[4]}, 32'h0000BEEF);
      chk("sram_hw5", {16'd0, mem[5]}, 32'h0000DEAD);
      // load it back
      do_op(1, 0, 1, 32'd1032, 32'h0, 4'd7, 32'hDEADBEEF, 5, 0, 0);
      // non-memory op: no stall, Mem_Data held
      do_op(0, 0, 1, 32'h55, 32'h0, 4'd3, 32'hDEADBEEF, 0, 0, 0);
      // conflicting request: read wins, no write
      do_op(1, 1, 1, 32'd1024, 32'h12345678, 4'd2, 32'h5A5AA5A5, 5, 0, 0);
      chk("conflict_no_wr_lo", {16'd0, mem[0]}, 32'h0000A5A5);
      chk("conflict_no_wr_hi", {16'd0, mem[1]}, 32'h00005A5A);

      // reset in the middle of RD_HI
      MEM_R_EN = 1; WB_EN = 1; ALU_Res = 32'd1024; Dest = 4'd5;
      repeat (3) @(posedge clk); #1;
      chk("rd_hi_addr", {14'd0, sram_addr}, 32'd1);
      chk("rd_hi_oe_n", {31'd0, sram_oe_n}, 32'd0);
      rst = 1; idle_in();
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("abort_oe_n", {31'd0, sram_oe_n}, 32'd1);
      chk("abort_mem_data", Mem_Data, 32'h0);
      chk("abort_ready", {31'd0, ready}, 32'd1);
      @(posedge clk); #1;
      do_op(1, 0, 1, 32'd1024, 32'h0, 4'd1, 32'h5A5AA5A5, 5, 0, 0);

      // back-to-back store/load at a wrapped address (halfword 0)
      do_op(0, 1, 0, 32'd1024 + 32'h0010_0000, 32'hCAFEF00D, 4'd0, 32'h5A5AA5A5, 7, 4, 6);
      do_op(1, 0, 1, 32'd1024 + 32'h0010_0000, 32'h0, 4'd9, 32'hCAFEF00D, 5, 0, 0);
      idle_in();
      chk("wrap_hw0", {16'd0, mem[0]}, 32'h0000F00D);
      chk("wrap_hw1", {16'd0, mem[1]}, 32'h0000CAFE);

      repeat (3) @(posedge clk);
      chk("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
